// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: iterative MULT/MULTU/DIV/DIVU sequencer attached to EX.
// One shift-add (multiply) or restoring-subtract (divide) step per clock, then a
// sign fixup that commits the 2*NB_DATA-bit result to HI/LO.
// Build option: define MULDIV_DIV_EN to include the divide path; without it,
// divide ops complete in one cycle and leave HI/LO untouched.
module ex_muldiv_seq #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_CNT  = 6,
  parameter int unsigned NB_OP   = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [NB_OP-1:0]   i_op,
  input  logic [NB_DATA-1:0] i_data_a,
  input  logic [NB_DATA-1:0] i_data_b,
  input  logic               i_flush,
  output logic               o_busy,
  output logic               o_stall,
  output logic               o_done,
  output logic               o_div_by_zero,
  output logic [NB_DATA-1:0] o_hi,
  output logic [NB_DATA-1:0] o_lo
);

  typedef enum logic [1:0] {StIdle, StRun, StFixup, StDone} state_e;

  localparam logic [NB_CNT-1:0] CntInit = NB_CNT'(NB_DATA);
  localparam logic [NB_CNT-1:0] CntLast = NB_CNT'(1);

  state_e               state_q, state_d;
  logic [NB_CNT-1:0]    cnt_q, cnt_d;
  // Multiply: {upper sum, multiplier}. Divide: {remainder, quotient}.
  logic [2*NB_DATA-1:0] acc_q, acc_d;
  // Multiplicand or divisor magnitude.
  logic [NB_DATA-1:0]   opnd_q, opnd_d;
  // Product sign (multiply) or quotient sign (divide).
  logic                 neg_res_q, neg_res_d;
  logic [NB_DATA-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic                 op_signed, op_div;
  logic [NB_DATA-1:0]   mag_a, mag_b;
  logic [NB_DATA:0]     mul_sum;
  logic [2*NB_DATA-1:0] mul_next, prod_fix;

  assign op_signed = ~i_op[0];
  assign op_div    = i_op[1];
  assign mag_a     = (op_signed && i_data_a[NB_DATA-1]) ? -i_data_a : i_data_a;
  assign mag_b     = (op_signed && i_data_b[NB_DATA-1]) ? -i_data_b : i_data_b;

  // Extra carry bit keeps the add exact before the right shift.
  assign mul_sum  = {1'b0, acc_q[2*NB_DATA-1:NB_DATA]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[NB_DATA-1:1]};
  assign prod_fix = neg_res_q ? -acc_q : acc_q;

`ifdef MULDIV_DIV_EN
  logic                 is_div_q, is_div_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 dbz_q, dbz_d;
  logic [NB_DATA:0]     div_trial;
  logic [2*NB_DATA-1:0] div_next;
  logic [NB_DATA-1:0]   quo_fix, rem_fix;

  // Trial subtract on the shifted remainder, including the bit shifted out of its top.
  assign div_trial = acc_q[2*NB_DATA-1:NB_DATA-1] - {1'b0, opnd_q};
  assign div_next  = div_trial[NB_DATA] ? {acc_q[2*NB_DATA-2:0], 1'b0}
                                        : {div_trial[NB_DATA-1:0], acc_q[NB_DATA-2:0], 1'b1};
  // With a zero divisor the remainder ends up as |a|, so the normal fixup restores a.
  assign quo_fix = dbz_q ? '1 :
                   (neg_res_q ? -acc_q[NB_DATA-1:0] : acc_q[NB_DATA-1:0]);
  assign rem_fix = neg_rem_q ? -acc_q[2*NB_DATA-1:NB_DATA] : acc_q[2*NB_DATA-1:NB_DATA];
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_res_d = neg_res_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
`ifdef MULDIV_DIV_EN
    is_div_d  = is_div_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (i_start && !i_flush) begin
`ifdef MULDIV_DIV_EN
          state_d   = StRun;
          cnt_d     = CntInit;
          is_div_d  = op_div;
          acc_d     = {{NB_DATA{1'b0}}, op_div ? mag_a : mag_b};
          opnd_d    = op_div ? mag_b : mag_a;
          neg_res_d = op_signed && (i_data_a[NB_DATA-1] ^ i_data_b[NB_DATA-1]);
          neg_rem_d = op_signed && i_data_a[NB_DATA-1];
          dbz_d     = op_div && (i_data_b == '0);
`else
          if (op_div) begin
            state_d = StDone;
          end else begin
            state_d   = StRun;
            cnt_d     = CntInit;
            acc_d     = {{NB_DATA{1'b0}}, mag_b};
            opnd_d    = mag_a;
            neg_res_d = op_signed && (i_data_a[NB_DATA-1] ^ i_data_b[NB_DATA-1]);
          end
`endif
        end
      end
      StRun: begin
        if (i_flush) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntLast;
`ifdef MULDIV_DIV_EN
          acc_d = is_div_q ? div_next : mul_next;
`else
          acc_d = mul_next;
`endif
          if (cnt_q == CntLast) state_d = StFixup;
        end
      end
      StFixup: begin
        if (i_flush) begin
          state_d = StIdle;
        end else begin
          state_d = StDone;
`ifdef MULDIV_DIV_EN
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*NB_DATA-1:NB_DATA];
            lo_d = prod_fix[NB_DATA-1:0];
          end
`else
          hi_d = prod_fix[2*NB_DATA-1:NB_DATA];
          lo_d = prod_fix[NB_DATA-1:0];
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef MULDIV_DIV_EN
      is_div_q  <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_res_q <= neg_res_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
`ifdef MULDIV_DIV_EN
      is_div_q  <= is_div_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
`endif
    end
  end

  assign o_busy  = (state_q != StIdle);
  assign o_stall = (state_q == StRun) || (state_q == StFixup);
  assign o_done  = (state_q == StDone);
  assign o_hi    = hi_q;
  assign o_lo    = lo_q;
`ifdef MULDIV_DIV_EN
  assign o_div_by_zero = (state_q == StDone) && dbz_q;
`else
  assign o_div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Bench for ex_muldiv_seq: directed and random ops against a plain-arithmetic model.
// Follows the DUT build: define MULDIV_DIV_EN for both to exercise the divider.
module tb_ex_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, stall, done, dbz;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_pass = 0;
  // Model's view of the architectural HI/LO.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  ex_muldiv_seq dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_op          (op),
    .i_data_a      (a),
    .i_data_b      (b),
    .i_flush       (flush),
    .o_busy        (busy),
    .o_stall       (stall),
    .o_done        (done),
    .o_div_by_zero (dbz),
    .o_hi          (hi),
    .o_lo          (lo)
  );

  always #5 clk = ~clk;

  // Expected HI/LO, div-by-zero flag and start-to-done latency from 64-bit arithmetic.
  task automatic model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                       output logic [31:0] e_hi, output logic [31:0] e_lo,
                       output logic e_dbz, output int e_lat);
    longint      sa, sb, p;
    logic [63:0] up;
    e_dbz = 1'b0;
    e_hi  = m_hi;
    e_lo  = m_lo;
    e_lat = 34;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    case (mop)
      2'b00: begin
        p = sa * sb;
        e_hi = p[63:32];
        e_lo = p[31:0];
      end
      2'b01: begin
        up = {32'h0, ma} * {32'h0, mb};
        e_hi = up[63:32];
        e_lo = up[31:0];
      end
      default: begin
`ifdef MULDIV_DIV_EN
        if (mb == 32'h0) begin
          e_dbz = 1'b1;
          e_lo  = 32'hFFFF_FFFF;
          e_hi  = ma;
        end else if (mop == 2'b10) begin
          if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
            e_lo = 32'h8000_0000;
            e_hi = 32'h0;
          end else begin
            p = sa / sb;
            e_lo = p[31:0];
            p = sa % sb;
            e_hi = p[31:0];
          end
        end else begin
          e_lo = ma / mb;
          e_hi = ma % mb;
        end
`else
        e_lat = 1;
`endif
      end
    endcase
  endtask

  // Issue one op from IDLE, wait (bounded) for o_done, return observations; ends in IDLE.
  task automatic run_op(input logic [1:0] rop, input logic [31:0] ra, input logic [31:0] rb,
                        output int lat, output int stalls, output logic [31:0] o_h,
                        output logic [31:0] o_l, output logic o_z);
    op = rop;
    a = ra;
    b = rb;
    start = 1'b1;
    stalls = 0;
    @(posedge clk); #1;
    start = 1'b0;
    // Operands only need to hold in the start cycle.
    a = $urandom;
    b = $urandom;
    op = 2'($urandom);
    lat = 1;
    while (!done && lat < 100) begin
      if (stall) stalls++;
      @(posedge clk); #1;
      lat++;
    end
    o_h = hi;
    o_l = lo;
    o_z = dbz;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++; if ({busy, stall, done, dbz} !== 4'b0)
      $display("FAIL reset_flags: got %b want 0000", {busy, stall, done, dbz}); else n_pass++;
    n_checks++; if (hi !== 32'h0) $display("FAIL reset_hi: got %h want 0", hi); else n_pass++;
    n_checks++; if (lo !== 32'h0) $display("FAIL reset_lo: got %h want 0", lo); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mult();
    logic [1:0]  ops [2] = '{2'b00, 2'b01};
    logic [31:0] as  [2] = '{32'h7, 32'hFFFF_FFFF};
    logic [31:0] bs  [2] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF};
    logic [31:0] e_hi, e_lo, o_h, o_l;
    logic        e_z, o_z;
    int          e_lat, lat, stalls;
    for (int i = 0; i < 2; i++) begin
      model(ops[i], as[i], bs[i], e_hi, e_lo, e_z, e_lat);
      m_hi = e_hi;
      m_lo = e_lo;
      run_op(ops[i], as[i], bs[i], lat, stalls, o_h, o_l, o_z);
      n_checks++; if (lat !== e_lat) $display("FAIL mult%0d_lat: got %0d want %0d", i, lat, e_lat);
      else n_pass++;
      n_checks++; if (stalls !== 33) $display("FAIL mult%0d_stall: got %0d want 33", i, stalls);
      else n_pass++;
      n_checks++; if (o_h !== e_hi) $display("FAIL mult%0d_hi: got %h want %h", i, o_h, e_hi);
      else n_pass++;
      n_checks++; if (o_l !== e_lo) $display("FAIL mult%0d_lo: got %h want %h", i, o_l, e_lo);
      else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL mult%0d_done_pulse: got %b want 0", i, done);
      else n_pass++;
    end
  endtask

  task automatic test_div();
    logic [1:0]  ops [3] = '{2'b10, 2'b10, 2'b11};
    logic [31:0] as  [3] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'h5};
    logic [31:0] bs  [3] = '{32'h2, 32'hFFFF_FFFF, 32'h0};
    logic [31:0] e_hi, e_lo, o_h, o_l;
    logic        e_z, o_z;
    int          e_lat, lat, stalls;
    for (int i = 0; i < 3; i++) begin
      model(ops[i], as[i], bs[i], e_hi, e_lo, e_z, e_lat);
      m_hi = e_hi;
      m_lo = e_lo;
      run_op(ops[i], as[i], bs[i], lat, stalls, o_h, o_l, o_z);
      n_checks++; if (lat !== e_lat) $display("FAIL div%0d_lat: got %0d want %0d", i, lat, e_lat);
      else n_pass++;
      n_checks++; if (o_h !== e_hi) $display("FAIL div%0d_hi: got %h want %h", i, o_h, e_hi);
      else n_pass++;
      n_checks++; if (o_l !== e_lo) $display("FAIL div%0d_lo: got %h want %h", i, o_l, e_lo);
      else n_pass++;
      n_checks++; if (o_z !== e_z) $display("FAIL div%0d_dbz: got %b want %b", i, o_z, e_z);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [1:0]  rop;
    logic [31:0] ra, rb, e_hi, e_lo, o_h, o_l;
    logic        e_z, o_z;
    int          e_lat, lat, stalls;
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: ra = 32'h8000_0000;
        2: rb = 32'($urandom_range(1, 9));
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      model(rop, ra, rb, e_hi, e_lo, e_z, e_lat);
      m_hi = e_hi;
      m_lo = e_lo;
      run_op(rop, ra, rb, lat, stalls, o_h, o_l, o_z);
      n_checks++; if (lat !== e_lat || o_h !== e_hi || o_l !== e_lo || o_z !== e_z)
        $display("FAIL rand%0d op=%b a=%h b=%h: got lat=%0d hi=%h lo=%h dbz=%b want lat=%0d hi=%h lo=%h dbz=%b",
                 i, rop, ra, rb, lat, o_h, o_l, o_z, e_lat, e_hi, e_lo, e_z);
      else n_pass++;
    end
  endtask

  task automatic test_flush();
    logic [31:0] e_hi, e_lo, o_h, o_l;
    logic        e_z, o_z;
    int          e_lat, lat, stalls, seen;
    model(2'b01, 32'h0001_2345, 32'h0004_5678, e_hi, e_lo, e_z, e_lat);
    m_hi = e_hi;
    m_lo = e_lo;
    run_op(2'b01, 32'h0001_2345, 32'h0004_5678, lat, stalls, o_h, o_l, o_z);
    n_checks++; if (o_h !== e_hi || o_l !== e_lo)
      $display("FAIL flush_preload: got %h/%h want %h/%h", o_h, o_l, e_hi, e_lo); else n_pass++;
    // Start a MULT and abort it in RUN cycle 10.
    op = 2'b00; a = $urandom; b = $urandom; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_checks++; if ({busy, stall} !== 2'b00)
      $display("FAIL flush_idle: got busy/stall=%b want 00", {busy, stall}); else n_pass++;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen++;
      @(posedge clk); #1;
    end
    n_checks++; if (seen !== 0) $display("FAIL flush_no_done: got %0d want 0", seen); else n_pass++;
    n_checks++; if (hi !== m_hi || lo !== m_lo)
      $display("FAIL flush_hilo: got %h/%h want %h/%h", hi, lo, m_hi, m_lo); else n_pass++;
    // Flush together with start in IDLE drops the start.
    op = 2'b01; a = 32'h3; b = 32'h4; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL flush_start_drop: got busy=%b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    op = 2'b00; a = $urandom; b = $urandom; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    m_hi = '0;
    m_lo = '0;
    n_checks++; if ({busy, stall, done, dbz} !== 4'b0 || hi !== m_hi || lo !== m_lo)
      $display("FAIL reset_mid: got flags=%b hi=%h lo=%h want 0000/0/0",
               {busy, stall, done, dbz}, hi, lo); else n_pass++;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, e_hi, e_lo, o_h, o_l;
    logic        e_z, o_z;
    int          e_lat, lat, stalls;
    a1 = $urandom;
    b1 = $urandom;
    model(2'b01, a1, b1, e_hi, e_lo, e_z, e_lat);
    m_hi = e_hi;
    m_lo = e_lo;
    op = 2'b01; a = a1; b = b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Foreign start in RUN cycle 5 must be ignored.
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
    op = 2'b00; a = ~a1; b = b1 ^ 32'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 6;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    n_checks++; if (lat !== e_lat) $display("FAIL ignore_lat: got %0d want %0d", lat, e_lat);
    else n_pass++;
    n_checks++; if (hi !== e_hi || lo !== e_lo)
      $display("FAIL ignore_result: got %h/%h want %h/%h", hi, lo, e_hi, e_lo); else n_pass++;
    @(posedge clk); #1;
    // Start in the cycle right after DONE, then again right after that one.
    for (int i = 0; i < 3; i++) begin
      a1 = $urandom;
      b1 = $urandom;
      model(2'(i), a1, b1, e_hi, e_lo, e_z, e_lat);
      m_hi = e_hi;
      m_lo = e_lo;
      run_op(2'(i), a1, b1, lat, stalls, o_h, o_l, o_z);
      n_checks++; if (lat !== e_lat || o_h !== e_hi || o_l !== e_lo)
        $display("FAIL b2b%0d: got lat=%0d hi=%h lo=%h want lat=%0d hi=%h lo=%h",
                 i, lat, o_h, o_l, e_lat, e_hi, e_lo); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_random();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
